sram_burst_sched: RTL and testbench
===================================

Name: sram_burst_sched

Overview:
- Schedules burst read/write commands from NUM_REQ requesters onto one single-port GB SRAM macro (A/DI/DO/WEB/CSB/DVS/DVSE, 1-cycle registered read).
- Arbitrates round-robin between requesters, locks the grant for a whole burst, and generates sequential addresses.
- Paces write beats with a handshake and returns read data tagged with the requester id.
- Sits between the GB loaders/PE fetch units and the SRAM instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 7, SRAM address width.
- DATA_WIDTH, 128, SRAM word width.
- LEN_WIDTH, 4, burst length field width (beats-1).
- DVS_VAL, 4'b0000, constant driven on sram_DVS.

Ports:
- clk  in  1  clock (also drives SRAM CK)
- rst  in  1  asynchronous reset, active-high
- req_vld  in  NUM_REQ  command valid per requester
- req_rdy  out  NUM_REQ  command accepted (one-hot, 1-cycle pulse)
- req_we  in  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst start address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*LEN_WIDTH  beats-1, packed the same way
- wr_vld  in  NUM_REQ  write beat valid
- wr_rdy  out  NUM_REQ  write beat accepted
- wr_data  in  NUM_REQ*DATA_WIDTH  write data, packed
- rsp_vld  out  1  read data valid
- rsp_id  out  $clog2(NUM_REQ)  owner of rsp_data
- rsp_last  out  1  final beat of a read burst
- rsp_data  out  DATA_WIDTH  read data (passthrough of sram_DO)
- sram_A  out  ADDR_WIDTH  SRAM address
- sram_DI  out  DATA_WIDTH  SRAM write data
- sram_DO  in  DATA_WIDTH  SRAM read data
- sram_WEB  out  1  0 = write
- sram_CSB  out  1  0 = select
- sram_DVS  out  4  tied to DVS_VAL
- sram_DVSE  out  1  tied 0

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, RR pointer=0.
  - req_rdy=0, wr_rdy=0, rsp_vld=0, rsp_last=0, rsp_id=0.
  - sram_CSB=1, sram_WEB=1, sram_A=0, sram_DI=0.
- Reset mid-burst drops the burst, with no further SRAM access; requesters must reissue.
- FSM IDLE:
  - If any req_vld, pick the first set bit scanning from the pointer upward with wrap.
  - Pulse req_rdy[g] for 1 cycle.
  - Latch g, req_we[g], req_addr[g] into cur_addr, and req_len[g] into remaining.
  - Set pointer=(g+1) mod NUM_REQ and go to BURST.
  - No SRAM access occurs in IDLE.
- FSM BURST, read:
  - Every cycle drive CSB=0, WEB=1, A=cur_addr.
  - Then cur_addr++ and remaining--.
  - The beat with remaining==0 is last: go to IDLE next cycle.
- FSM BURST, write:
  - wr_rdy[g]=1 (combinational, others 0).
  - When wr_vld[g]: CSB=0, WEB=0, A=cur_addr, DI=wr_data[g]; then increment/decrement as for reads.
  - When !wr_vld[g]: CSB=1, nothing else advances (stall, unbounded).
- SRAM control outputs are combinational from the state registers and wr_vld.
- Read response: rsp_vld, rsp_id and rsp_last are registered from the issue cycle, so they are valid exactly 1 cycle after the read issue, aligned with sram_DO.
  - rsp_data=sram_DO combinationally.
  - There is no response backpressure: requesters must always sink.
- Address wraps modulo 2^ADDR_WIDTH inside a burst.
- Burst length is req_len+1, in the range 1..2^LEN_WIDTH.
- Per-burst overhead is 1 IDLE bubble cycle; peak throughput is N/(N+1) beats per cycle.
- Simultaneous requests are round-robin; a requester is re-granted only after all others with pending req_vld are served.
- req_* changes while not granted are ignored; they are sampled only on the req_rdy cycle.
- req_vld from a requester whose index is ≥ NUM_REQ is impossible by width.

Decomposition:
- Shared package (gb_sched_pkg):
  - FSM state enum {IDLE, BURST}.
  - ID_WIDTH=$clog2(NUM_REQ) helper.
  - DVS default constant.
- Sub-module rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant plus encoded index out, purely combinational.
- The pointer register stays in sram_burst_sched.

Test Plan:
- Single read, len=0, addr=5, SRAM preloaded [5]=A5 → exactly one CSB=0/WEB=1 cycle with A=5; next cycle rsp_vld=1, rsp_data=A5, rsp_last=1, rsp_id=0.
- Write burst from req1, addr=126, len=3, wr_vld gapped (1,0,1,1,0,1) → SRAM writes at 126,127,0,1 with no write on gap cycles; readback burst returns data in order, last flag on beat 4.
- Both requesters hold req_vld continuously with len=1 → grants alternate 0,1,0,1; each burst is 2 beats plus 1 bubble; neither requester starves.
- rst asserted on the 2nd beat of a len=7 read → CSB=1 immediately; rsp_vld=0 next cycle; pointer=0; a new request is granted normally after release.
- Max burst len=15 read at addr=120 → 16 consecutive issue cycles; addresses 120..127 then 0..7; rsp_last only on the 16th response.
- Requester 0 asserts req_vld during requester 1's write stall → no grant change and no req_rdy[0] until requester 1's last beat; then requester 0 is granted after 1 idle cycle.

Source files
------------

// File: rtl/gb_sched_pkg.sv
// Shared definitions for the GB SRAM burst scheduler.
// Contents: FSM state encodings, requester-id width helper, default DVS value.
package gb_sched_pkg;

    localparam int unsigned DVS_WIDTH = 4;
    localparam logic [DVS_WIDTH-1:0] DVS_DEFAULT = 4'b0000;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Requester id width; never below 1 so a 1-bit id field always exists
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i     request vector, one bit per requester
//   ptr_i     highest-priority index; scanning goes upward from here with wrap
//   gnt_o     one-hot grant
//   gnt_id_o  encoded grant index
//   gnt_vld_o at least one request present
module rr_arbiter
    import gb_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                gnt_vld_o
);

    localparam int unsigned SW = ID_WIDTH + 1;

    logic [SW-1:0] idx;

    // First set bit at or above ptr_i, wrapping modulo NUM_REQ
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, ptr_i} + SW'(off);
            if (idx >= SW'(NUM_REQ)) begin
                idx = idx - SW'(NUM_REQ);
            end
            if (!gnt_vld_o && req_i[idx[ID_WIDTH-1:0]]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = idx[ID_WIDTH-1:0];
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_burst_sched.sv
// Burst scheduler in front of one single-port GB SRAM macro.
// Round-robin arbitration between NUM_REQ requesters; the grant is held for a
// whole burst while sequential addresses are issued. Write beats are paced by
// wr_vld/wr_rdy; read data returns one cycle after issue, tagged with the owner.
// Ports:
//   clk, rst                       clock / async active-high reset
//   req_vld/req_rdy/req_we/
//   req_addr/req_len               burst command per requester (packed vectors)
//   wr_vld/wr_rdy/wr_data          write beat handshake per requester
//   rsp_vld/rsp_id/rsp_last/
//   rsp_data                       read response (no backpressure)
//   sram_*                         SRAM macro pins
module sram_burst_sched
    import gb_sched_pkg::*;
#(
    parameter int unsigned            NUM_REQ    = 2,
    parameter int unsigned            ADDR_WIDTH = 7,
    parameter int unsigned            DATA_WIDTH = 128,
    parameter int unsigned            LEN_WIDTH  = 4,
    parameter logic [DVS_WIDTH-1:0]   DVS_VAL    = DVS_DEFAULT,
    localparam int unsigned           ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_vld,
    output logic [NUM_REQ-1:0]               req_rdy,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
    input  logic [NUM_REQ-1:0]               wr_vld,
    output logic [NUM_REQ-1:0]               wr_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
    output logic                             rsp_vld,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic                             rsp_last,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ADDR_WIDTH-1:0]            sram_A,
    output logic [DATA_WIDTH-1:0]            sram_DI,
    input  logic [DATA_WIDTH-1:0]            sram_DO,
    output logic                             sram_WEB,
    output logic                             sram_CSB,
    output logic [DVS_WIDTH-1:0]             sram_DVS,
    output logic                             sram_DVSE
);

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   gid_q, gid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic                  rsp_last_q, rsp_last_d;

    logic                  issue;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [ID_WIDTH-1:0]   arb_id;
    logic                  arb_vld;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_i     (req_vld),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_id),
        .gnt_vld_o (arb_vld)
    );

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gid_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // Next-state and handshake logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rsp_vld_d  = 1'b0;
        rsp_id_d   = rsp_id_q;
        rsp_last_d = 1'b0;
        req_rdy    = '0;
        wr_rdy     = '0;
        issue      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gate with rst so no command is acknowledged while held in reset
                if (arb_vld && !rst) begin
                    req_rdy = arb_gnt;
                    gid_d   = arb_id;
                    we_d    = req_we[arb_id];
                    addr_d  = req_addr[32'(arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    rem_d   = req_len[32'(arb_id)*LEN_WIDTH +: LEN_WIDTH];
                    ptr_d   = (arb_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (we_q) begin
                    wr_rdy[gid_q] = 1'b1;
                    issue         = wr_vld[gid_q];
                end else begin
                    issue = 1'b1;
                end
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                    end
                    if (!we_q) begin
                        rsp_vld_d  = 1'b1;
                        rsp_id_d   = gid_q;
                        rsp_last_d = (rem_q == '0);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM pins follow the issue decision in the same cycle
    assign sram_CSB  = ~issue;
    assign sram_WEB  = ~(issue & we_q);
    assign sram_A    = issue ? addr_q : '0;
    assign sram_DI   = (issue && we_q) ? wr_data[32'(gid_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign sram_DVS  = DVS_VAL;
    assign sram_DVSE = 1'b0;

    // Response metadata lines up with the macro's registered read data
    assign rsp_vld  = rsp_vld_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_last = rsp_last_q;
    assign rsp_data = sram_DO;

endmodule

// File: tb/tb_sram_burst_sched.sv
module tb_sram_burst_sched;

    localparam int AW = 7;
    localparam int DW = 128;
    localparam int LW = 4;
    localparam int N  = 2;
    localparam int DEPTH = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_we  = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len  = '0;
    logic [N-1:0]    wr_vld  = '0;
    logic [N*DW-1:0] wr_data = '0;
    logic [N-1:0]    req_rdy, wr_rdy;
    logic            rsp_vld, rsp_last;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   sram_A;
    logic [DW-1:0]   sram_DI, sram_DO;
    logic            sram_WEB, sram_CSB, sram_DVSE;
    logic [3:0]      sram_DVS;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    sram_burst_sched dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data),
        .sram_A(sram_A), .sram_DI(sram_DI), .sram_DO(sram_DO),
        .sram_WEB(sram_WEB), .sram_CSB(sram_CSB), .sram_DVS(sram_DVS), .sram_DVSE(sram_DVSE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] v;
        if (a == 5) return 128'hA5;
        v = '0;
        v[127:112] = 16'h5A5A;
        v[111:104] = 8'(a);
        v[7:0]     = 8'(a);
        return v;
    endfunction

    function automatic logic [DW-1:0] wdat(input int k, input int tag);
        logic [DW-1:0] v;
        v = '0;
        v[127:96] = 32'hDEAD_0000 + 32'(tag * 256 + k);
        v[31:0]   = 32'(k + 1);
        return v;
    endfunction

    // Behavioural single-port SRAM with 1-cycle registered read
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout;
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (rst && !loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            loaded <= 1'b1;
        end else if (!sram_CSB) begin
            if (!sram_WEB) mem[sram_A] <= sram_DI;
            else           dout <= mem[sram_A];
        end
    end
    assign sram_DO = dout;

    // Expected memory contents as tracked by the bench
    logic [DW-1:0] exp_mem [DEPTH];

    typedef struct { int cyc; logic web; logic [AW-1:0] a; logic [DW-1:0] di; } acc_t;
    typedef struct { int cyc; logic id; logic last; logic [DW-1:0] d; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    always @(negedge clk) begin
        if (!sram_CSB) acc_q.push_back('{cyc, sram_WEB, sram_A, sram_DI});
        if (rsp_vld)   rsp_q.push_back('{cyc, rsp_id[0], rsp_last, rsp_data});
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Present a command from requester id; returns at posedge+1 after acceptance
    task automatic issue(input int id, input logic we, input int addr, input int len);
        bit got;
        logic [N-1:0] seen;
        got  = 1'b0;
        seen = '0;
        req_vld[id] = 1'b1;
        req_we[id]  = we;
        req_addr[id*AW +: AW] = 7'(addr);
        req_len[id*LW +: LW]  = 4'(len);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_rdy[id]) begin
                got  = 1'b1;
                seen = req_rdy;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL issue_timeout: requester %0d req_rdy got 0 required 1", id);
        end else begin
            chk("req_rdy_onehot", 128'(seen), 128'(1) << id);
        end
        @(posedge clk); #1;
        req_vld[id] = 1'b0;
    endtask

    typedef struct { int id; int addr; int len; int exp_beats; int exp_last_a; } rd_vec_t;
    rd_vec_t vt[5];

    initial begin
        int ba, br, k, lw_cyc;
        int gids[$];
        int gcyc[$];
        int wpat[6];
        int spat[6];
        logic [DW-1:0] e;

        // Read bursts: {id, addr, len, beats, last address}
        vt[0] = '{0,   5,  0,  1,   5};
        vt[1] = '{1, 126,  3,  4,   1};
        vt[2] = '{0, 127,  1,  2,   0};
        vt[3] = '{1,   0,  2,  3,   2};
        vt[4] = '{0, 120, 15, 16,   7};

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);

        // Reset state, with requests pending to show they are ignored
        req_vld = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_req_rdy", 128'(req_rdy), 0);
        chk("rst_wr_rdy", 128'(wr_rdy), 0);
        chk("rst_rsp_vld", 128'(rsp_vld), 0);
        chk("rst_rsp_last", 128'(rsp_last), 0);
        chk("rst_rsp_id", 128'(rsp_id), 0);
        chk("rst_csb", 128'(sram_CSB), 1);
        chk("rst_web", 128'(sram_WEB), 1);
        chk("rst_a", 128'(sram_A), 0);
        chk("rst_di", sram_DI, 0);
        chk("dvs", 128'(sram_DVS), 0);
        chk("dvse", 128'(sram_DVSE), 0);
        @(posedge clk); #1;
        req_vld = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven read bursts
        for (int i = 0; i < 5; i++) begin
            ba = acc_q.size();
            br = rsp_q.size();
            issue(vt[i].id, 1'b0, vt[i].addr, vt[i].len);
            repeat (vt[i].len + 4) @(posedge clk);
            #1;
            chk("rd_beats", 128'(acc_q.size() - ba), 128'(vt[i].exp_beats));
            chk("rd_rsps", 128'(rsp_q.size() - br), 128'(vt[i].exp_beats));
            if (acc_q.size() - ba == vt[i].exp_beats && rsp_q.size() - br == vt[i].exp_beats) begin
                chk("rd_first_a", 128'(acc_q[ba].a), 128'(vt[i].addr));
                chk("rd_last_a", 128'(acc_q[ba + vt[i].exp_beats - 1].a), 128'(vt[i].exp_last_a));
                for (int b = 0; b < vt[i].exp_beats; b++) begin
                    chk("rd_web", 128'(acc_q[ba+b].web), 1);
                    chk("rd_a", 128'(acc_q[ba+b].a), 128'((vt[i].addr + b) % DEPTH));
                    chk("rd_cyc", 128'(acc_q[ba+b].cyc - acc_q[ba].cyc), 128'(b));
                    chk("rsp_lat", 128'(rsp_q[br+b].cyc - acc_q[ba+b].cyc), 1);
                    chk("rsp_data", rsp_q[br+b].d, exp_mem[(vt[i].addr + b) % DEPTH]);
                    chk("rsp_id", 128'(rsp_q[br+b].id), 128'(vt[i].id));
                    chk("rsp_last", 128'(rsp_q[br+b].last), 128'(b == vt[i].exp_beats - 1));
                end
                if (i == 0) chk("t1_a5", rsp_q[br].d, 128'hA5);
            end
        end

        // Gapped write burst from requester 1 across the address wrap
        wpat = '{1, 0, 1, 1, 0, 1};
        ba = acc_q.size();
        issue(1, 1'b1, 126, 3);
        k = 0;
        for (int j = 0; j < 6; j++) begin
            wr_vld[1] = wpat[j][0];
            wr_data[DW +: DW] = wpat[j] != 0 ? wdat(k, 1) : '0;
            @(negedge clk);
            chk("wr_rdy", 128'(wr_rdy), 128'(2'b10));
            if (wpat[j] == 0) chk("wr_gap_csb", 128'(sram_CSB), 1);
            @(posedge clk); #1;
            k += wpat[j];
        end
        wr_vld = '0;
        @(negedge clk);
        chk("wr_done_rdy", 128'(wr_rdy), 0);
        chk("wr_count", 128'(acc_q.size() - ba), 4);
        if (acc_q.size() - ba == 4) begin
            for (int b = 0; b < 4; b++) begin
                chk("wr_web", 128'(acc_q[ba+b].web), 0);
                chk("wr_a", 128'(acc_q[ba+b].a), 128'((126 + b) % DEPTH));
                chk("wr_di", acc_q[ba+b].di, wdat(b, 1));
            end
        end
        for (int b = 0; b < 4; b++) exp_mem[(126 + b) % DEPTH] = wdat(b, 1);
        @(posedge clk); #1;

        // Readback of the written burst
        br = rsp_q.size();
        issue(1, 1'b0, 126, 3);
        repeat (7) @(posedge clk);
        #1;
        chk("rb_rsps", 128'(rsp_q.size() - br), 4);
        if (rsp_q.size() - br == 4) begin
            for (int b = 0; b < 4; b++) begin
                chk("rb_data", rsp_q[br+b].d, wdat(b, 1));
                chk("rb_last", 128'(rsp_q[br+b].last), 128'(b == 3));
            end
        end

        // Both requesters hold req_vld: grants alternate with one bubble per burst
        req_addr = {7'd20, 7'd10};
        req_len  = {4'd1, 4'd1};
        req_we   = '0;
        br = rsp_q.size();
        req_vld = 2'b11;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (|req_rdy) begin
                gids.push_back(req_rdy[1] ? 1 : 0);
                gcyc.push_back(cyc);
            end
            @(posedge clk); #1;
            if (gids.size() == 4) break;
        end
        req_vld = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("rr_grants", 128'(gids.size()), 4);
        if (gids.size() == 4) begin
            for (int g = 0; g < 4; g++) begin
                chk("rr_order", 128'(gids[g]), 128'(g % 2));
                if (g > 0) chk("rr_spacing", 128'(gcyc[g] - gcyc[g-1]), 3);
            end
        end
        chk("rr_rsps", 128'(rsp_q.size() - br), 8);
        if (rsp_q.size() - br == 8) begin
            for (int b = 0; b < 8; b++) begin
                chk("rr_rsp_id", 128'(rsp_q[br+b].id), 128'((b / 2) % 2));
                e = exp_mem[((b / 2) % 2 == 0 ? 10 : 20) + (b % 2)];
                chk("rr_rsp_data", rsp_q[br+b].d, e);
                chk("rr_rsp_last", 128'(rsp_q[br+b].last), 128'(b % 2));
            end
        end

        // Reset on the second beat of a len=7 read
        ba = acc_q.size();
        br = rsp_q.size();
        issue(0, 1'b0, 40, 7);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_csb", 128'(sram_CSB), 1);
        chk("rst_mid_rsp", 128'(rsp_vld), 0);
        @(posedge clk); #1;
        chk("rst_next_rsp", 128'(rsp_vld), 0);
        chk("rst_next_csb", 128'(sram_CSB), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_accesses", 128'(acc_q.size() - ba), 1);
        chk("rst_rsps", 128'(rsp_q.size() - br), 0);
        // Pointer back to 0: with both requesting, requester 0 wins
        req_addr = {7'd0, 7'd3};
        req_len  = '0;
        req_vld  = 2'b11;
        k = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (|req_rdy) begin
                chk("rst_ptr_gnt", 128'(req_rdy), 128'(2'b01));
                k = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_regrant", 128'(k), 1);
        @(posedge clk); #1;
        req_vld = '0;
        repeat (4) @(posedge clk);
        #1;

        // Requester 0 waits through requester 1's stalled write burst
        spat = '{0, 0, 0, 1, 0, 1};
        ba = acc_q.size();
        issue(1, 1'b1, 50, 1);
        req_we[0] = 1'b0;
        req_addr[0 +: AW] = 7'd50;
        req_len[0 +: LW]  = 4'd1;
        req_vld[0] = 1'b1;
        k = 0;
        for (int j = 0; j < 6; j++) begin
            wr_vld[1] = spat[j][0];
            wr_data[DW +: DW] = spat[j] != 0 ? wdat(k, 2) : '0;
            @(negedge clk);
            chk("stall_no_gnt", 128'(req_rdy), 0);
            chk("stall_wr_rdy", 128'(wr_rdy), 128'(2'b10));
            @(posedge clk); #1;
            k += spat[j];
        end
        wr_vld = '0;
        lw_cyc = (acc_q.size() > 0) ? acc_q[acc_q.size()-1].cyc : -100;
        @(negedge clk);
        chk("stall_gnt0", 128'(req_rdy), 128'(2'b01));
        chk("stall_bubble", 128'(cyc - lw_cyc), 1);
        chk("stall_writes", 128'(acc_q.size() - ba), 2);
        exp_mem[50] = wdat(0, 2);
        exp_mem[51] = wdat(1, 2);
        br = rsp_q.size();
        @(posedge clk); #1;
        req_vld = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_rb_rsps", 128'(rsp_q.size() - br), 2);
        if (rsp_q.size() - br == 2) begin
            chk("stall_rb_d0", rsp_q[br].d, exp_mem[50]);
            chk("stall_rb_d1", rsp_q[br+1].d, exp_mem[51]);
            chk("stall_rb_id", 128'(rsp_q[br+1].id), 0);
            chk("stall_rb_last", 128'(rsp_q[br+1].last), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
